// File: rtl/urng_pair_packer.sv
// urng_pair_packer: packs pairs of uniform words into a registered {u0, u1} Box-Muller operand slot.
// Optional macro URNG_PACK_ZERO_GUARD_EN substitutes u0=1 for a zero u0 and sets zero_seen.
module urng_pair_packer #(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int U0_W   = DATA_W + DATA_W / 2,
    localparam int U1_W   = DATA_W / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [U0_W-1:0]   out_u0,
    output logic [U1_W-1:0]   out_u1,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              zero_seen
);
    typedef enum logic {S_A, S_B} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] hold_a;
    logic              accept, load, drain;
    logic [U0_W-1:0]   u0_packed, u0_load;

    // the output slot can take a new sample when empty or draining on this edge
    assign in_ready  = rst && !flush && (state == S_A || !out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && state == S_B;
    assign drain     = out_valid && out_ready;
    assign u0_packed = {hold_a, in_data[DATA_W-1:DATA_W/2]};

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = S_A;
        else if (accept)
            state_nx = (state == S_A) ? S_B : S_A;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_A;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_a     <= '0;
            out_valid  <= 1'b0;
            out_u0     <= '0;
            out_u1     <= '0;
            sample_cnt <= '0;
        end else begin
            if (flush)
                hold_a <= '0;
            else if (accept && state == S_A)
                hold_a <= in_data;
            if (load) begin
                out_u0 <= u0_load;
                out_u1 <= in_data[U1_W-1:0];
            end
            out_valid <= load || (out_valid && !out_ready);
            if (drain)
                sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

`ifdef URNG_PACK_ZERO_GUARD_EN
    // keep ln(u0) finite downstream
    assign u0_load = (u0_packed == '0) ? U0_W'(1) : u0_packed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            zero_seen <= 1'b0;
        else if (load && u0_packed == '0)
            zero_seen <= 1'b1;
    end
`else
    assign u0_load   = u0_packed;
    assign zero_seen = 1'b0;
`endif
endmodule

// File: tb/tb_urng_pair_packer.sv
// tb_urng_pair_packer: directed scenario tests for urng_pair_packer (CNT_W=4 to reach counter wrap).
module tb_urng_pair_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_u0;
    logic [15:0] out_u1;
    logic [3:0]  sample_cnt;
    logic        zero_seen;
    int          checks = 0;
    int          errors = 0;

    urng_pair_packer #(.DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_u0(out_u0), .out_u1(out_u1), .sample_cnt(sample_cnt), .zero_seen(zero_seen)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // offer a word and return 1 ns after the edge where it was accepted
    task automatic send(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout: word %h not accepted, required acceptance within 20 cycles", d);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        checks++; if (sample_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d need 0", sample_cnt); end
        checks++; if (out_u0 !== 48'h0 || out_u1 !== 16'h0) begin errors++; $display("FAIL rst_data: got %h/%h need 0/0", out_u0, out_u1); end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_basic_pair();
        do_reset();
        out_ready = 1'b1;
        send(32'h12345678);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_half_valid: got %b need 0", out_valid); end
        send(32'h9ABCDEF0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b need 1", out_valid); end
        checks++; if (out_u0 !== 48'h123456789ABC) begin errors++; $display("FAIL basic_u0: got %h need 123456789abc", out_u0); end
        checks++; if (out_u1 !== 16'hDEF0) begin errors++; $display("FAIL basic_u1: got %h need def0", out_u1); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b need 0", out_valid); end
        checks++; if (sample_cnt !== 4'd1) begin errors++; $display("FAIL basic_cnt: got %0d need 1", sample_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send(32'h1);
        send(32'h2);
        send(32'h3);
        in_valid = 1'b1; in_data = 32'h4;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b need 0", in_ready); end
        checks++; if (out_u0 !== 48'h000000010000 || out_u1 !== 16'h0002) begin errors++; $display("FAIL bp_hold: got %h/%h need 000000010000/0002", out_u0, out_u1); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follows: got %b need 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stays: got %b need 1", out_valid); end
        checks++; if (out_u0 !== 48'h000000030000 || out_u1 !== 16'h0004) begin errors++; $display("FAIL bp_sample2: got %h/%h need 000000030000/0004", out_u0, out_u1); end
        checks++; if (sample_cnt !== 4'd1) begin errors++; $display("FAIL bp_cnt1: got %0d need 1", sample_cnt); end
        @(posedge clk); #1;
        checks++; if (sample_cnt !== 4'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_cnt2: got %0d/%b need 2/0", sample_cnt, out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        send(32'hFFFFFFFF);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h00000001;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b need 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        send(32'h00000001);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_half: got valid %b need 0", out_valid); end
        send(32'h00020003);
        checks++; if (out_valid !== 1'b1 || out_u0 !== 48'h000000010002 || out_u1 !== 16'h0003) begin errors++; $display("FAIL flush_sample: got %b %h/%h need 1 000000010002/0003", out_valid, out_u0, out_u1); end
    endtask

    task automatic test_zero_guard();
        do_reset();
        out_ready = 1'b1;
        send(32'h00000000);
        send(32'h0000ABCD);
        checks++; if (out_u1 !== 16'hABCD) begin errors++; $display("FAIL zg_u1: got %h need abcd", out_u1); end
`ifdef URNG_PACK_ZERO_GUARD_EN
        checks++; if (out_u0 !== 48'h1) begin errors++; $display("FAIL zg_u0: got %h need 1", out_u0); end
        @(posedge clk); #1;
        checks++; if (zero_seen !== 1'b1) begin errors++; $display("FAIL zg_seen: got %b need 1", zero_seen); end
`else
        checks++; if (out_u0 !== 48'h0) begin errors++; $display("FAIL zg_u0: got %h need 0", out_u0); end
        @(posedge clk); #1;
        checks++; if (zero_seen !== 1'b0) begin errors++; $display("FAIL zg_seen: got %b need 0", zero_seen); end
`endif
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd1;
        for (int i = 1; i <= 35; i++) begin
            @(posedge clk); #1;
            if (i >= 34) in_valid = 1'b0;
            in_data = i + 1;
            checks++;
            if (out_valid !== (i % 2 == 0) || sample_cnt !== 4'(((i - 1) / 2) % 16)) begin
                errors++;
                $display("FAIL wrap_cycle%0d: got valid %b cnt %0d need %b %0d", i, out_valid, sample_cnt, (i % 2 == 0), ((i - 1) / 2) % 16);
            end
            if (i < 34) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready%0d: got %b need 1", i, in_ready); end
            end
            if (i == 33) begin
                checks++; if (sample_cnt !== 4'd0) begin errors++; $display("FAIL wrap_16th: got %0d need 0", sample_cnt); end
            end
            if (i == 34) begin
                checks++; if (out_u0 !== {32'd33, 16'd0} || out_u1 !== 16'd34) begin errors++; $display("FAIL wrap_last_data: got %h/%h need %h/%h", out_u0, out_u1, {32'd33, 16'd0}, 16'd34); end
            end
        end
        checks++; if (sample_cnt !== 4'd1) begin errors++; $display("FAIL wrap_17th: got %0d need 1", sample_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_backpressure();
        test_flush();
        test_zero_guard();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
